otter_uart_mmio: RTL

Memory-mapped UART peripheral for the OTTER MMIO space (addresses ≥ 0x00010000). It sits directly downstream of the memory block's MMIO path:
- It consumes the data-port address, store data and IO write strobe.
- It returns its read data on the memory's IO input, which the memory registers on a data read.

It provides a buffered 8N1 transmitter, a single-byte receiver and a status register, so firmware can print and poll without stalling the core.

---
 rtl/otter_uart_mmio.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/otter_uart_mmio.sv
// OTTER MMIO UART: memory-mapped 8N1 transmitter with a TX FIFO, a single-byte
// receiver behind a 2-flop synchronizer, and a polled status register.
module otter_uart_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h11000000,
  parameter int          BAUD_DIV   = 868,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IO_ADDR,
  input  logic        IO_WR,
  input  logic        IO_RD,
  input  logic [31:0] IO_DIN,
  output logic [31:0] IO_OUT,
  output logic        TX,
  input  logic        RX,
  output logic [1:0]  dbg_tx_state,
  output logic [1:0]  dbg_rx_state
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [15:0] FULL_M1 = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'((BAUD_DIV / 2) - 1);

  localparam logic [31:0] ADDR_TXDATA = BASE_ADDR;
  localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'd4;
  localparam logic [31:0] ADDR_RXDATA = BASE_ADDR + 32'd8;

  // Bus handshake: IO_WR/IO_RD are single-cycle strobes with no ready; a TX
  // push that finds the FIFO full is dropped and firmware polls tx_full.
  logic       push_req;
  logic       push_ok;
  logic       tx_pop;
  logic       rx_clear;
  logic       unused_din;

  assign push_req   = IO_WR && (IO_ADDR == ADDR_TXDATA);
  assign rx_clear   = IO_RD && (IO_ADDR == ADDR_RXDATA);
  assign unused_din = ^IO_DIN[31:8];

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  assign fifo_full  = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign push_ok    = push_req && (!fifo_full || tx_pop);

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= IO_DIN[7:0];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (tx_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, tx_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------------------------------------------------------- TX FSM
  logic [1:0]  tx_state;
  logic [15:0] tx_baud;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_tick;
  logic        tx_busy;

  assign tx_tick = (tx_baud == FULL_M1);
  assign tx_busy = (tx_state != ST_IDLE);
  assign tx_pop  = !fifo_empty &&
                   ((tx_state == ST_IDLE) || ((tx_state == ST_STOP) && tx_tick));
  assign dbg_tx_state = tx_state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_state <= ST_IDLE;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      TX       <= 1'b1;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          if (tx_pop) begin
            tx_state <= ST_START;
            tx_shift <= fifo_mem[rd_ptr];
            tx_bit   <= '0;
            tx_baud  <= '0;
            TX       <= 1'b0;
          end
        end
        ST_START: begin
          if (tx_tick) begin
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_state <= ST_DATA;
            TX       <= tx_shift[0];
          end else begin
            tx_baud <= tx_baud + 1'b1;
          end
        end
        ST_DATA: begin
          if (tx_tick) begin
            tx_baud <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= ST_STOP;
              TX       <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              TX       <= tx_shift[1];
            end
          end else begin
            tx_baud <= tx_baud + 1'b1;
          end
        end
        ST_STOP: begin
          if (tx_tick) begin
            tx_baud <= '0;
            // Chain straight into the next start bit so queued frames abut.
            if (tx_pop) begin
              tx_state <= ST_START;
              tx_shift <= fifo_mem[rd_ptr];
              tx_bit   <= '0;
              TX       <= 1'b0;
            end else begin
              tx_state <= ST_IDLE;
            end
          end else begin
            tx_baud <= tx_baud + 1'b1;
          end
        end
        default: begin
          tx_state <= ST_IDLE;
          TX       <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- RX path
  logic [1:0]  rx_sync;
  logic        rx_s;
  logic        rx_prev;
  logic [1:0]  rx_state;
  logic [15:0] rx_baud;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_deliver;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_overrun;

  assign rx_s         = rx_sync[1];
  assign rx_deliver   = (rx_state == ST_STOP) && (rx_baud == FULL_M1) && rx_s;
  assign dbg_rx_state = rx_state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], RX};
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_state <= ST_IDLE;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        ST_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_state <= ST_START;
            rx_baud  <= '0;
          end
        end
        ST_START: begin
          // Half a bit in: a line that has already returned high was a glitch.
          if (rx_baud == HALF_M1) begin
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_baud == FULL_M1) begin
            rx_baud  <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
              rx_state <= ST_STOP;
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
        ST_STOP: begin
          if (rx_baud == FULL_M1) begin
            rx_baud  <= '0;
            rx_state <= ST_IDLE;
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  // A delivery on the same edge as an RXDATA read wins and starts clean.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else if (rx_deliver) begin
      rx_data    <= rx_shift;
      rx_valid   <= 1'b1;
      rx_overrun <= rx_clear ? 1'b0 : (rx_overrun || rx_valid);
    end else if (rx_clear) begin
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- read mux
  always_comb begin
    IO_OUT = '0;
    if (IO_ADDR == ADDR_STATUS) begin
      IO_OUT = {27'd0, rx_overrun, rx_valid, tx_busy, fifo_full, fifo_empty};
    end else if (IO_ADDR == ADDR_RXDATA) begin
      IO_OUT = {24'd0, rx_data};
    end
  end

endmodule
